// File: rtl/multi_dataflow_job_dispatcher.sv
// Peripheral-bus master that acquires an hwpe_ctrl context, programs the job
// registers from a start-time snapshot, triggers the job and waits for its event.
module multi_dataflow_job_dispatcher #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned N_JOB_REGS     = 8,
  parameter logic [31:0] JOB_REG_OFFS   = 32'h40,
  parameter int unsigned ID_WIDTH       = 10,
  parameter int unsigned ID_VAL         = 0,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [7:0]              job_id_o,
  input  logic                    evt_i,
  output logic                    periph_req_o,
  input  logic                    periph_gnt_i,
  output logic [31:0]             periph_add_o,
  output logic                    periph_wen_o,
  output logic [3:0]              periph_be_o,
  output logic [31:0]             periph_data_o,
  output logic [ID_WIDTH-1:0]     periph_id_o,
  input  logic [31:0]             periph_r_data_i,
  input  logic                    periph_r_valid_i
);

  localparam int unsigned IDX_W      = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam logic [31:0] TRIG_ADDR  = BASE_ADDR;
  localparam logic [31:0] ACQ_ADDR   = BASE_ADDR + 32'd4;

  typedef enum logic [3:0] {
    IDLE, ACQ_REQ, ACQ_RESP, BACKOFF, WR_REQ, WR_RESP, TRIG_REQ, TRIG_RESP, WAIT_EVT
  } state_t;

  state_t           state;
  logic [31:0]      snap [N_JOB_REGS];
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] k_inc;
  logic [31:0]      retry_cnt;
  logic [31:0]      bo_cnt;
  logic             evt_flag;

  assign k_inc       = k + 1'b1;
  assign periph_be_o = 4'hF;
  assign periph_id_o = ID_WIDTH'(ID_VAL);

  function automatic logic [31:0] job_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + JOB_REG_OFFS + (32'(idx) << 2);
  endfunction

  // Bus outputs are loaded together with the transition into a *_REQ state,
  // so req/add/wen/data are registered and stay put until the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      periph_req_o  <= 1'b0;
      periph_add_o  <= '0;
      periph_wen_o  <= 1'b1;
      periph_data_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      job_id_o      <= '0;
      k             <= '0;
      retry_cnt     <= '0;
      bo_cnt        <= '0;
      evt_flag      <= 1'b0;
      for (int unsigned i = 0; i < N_JOB_REGS; i++) snap[i] <= '0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            for (int unsigned i = 0; i < N_JOB_REGS; i++) snap[i] <= job_regs_i[32*i +: 32];
            retry_cnt     <= '0;
            busy_o        <= 1'b1;
            periph_req_o  <= 1'b1;
            periph_add_o  <= ACQ_ADDR;
            periph_wen_o  <= 1'b1;
            periph_data_o <= '0;
            state         <= ACQ_REQ;
          end
        end
        ACQ_REQ, WR_REQ, TRIG_REQ: begin
          if (periph_gnt_i) begin
            periph_req_o <= 1'b0;
            case (state)
              ACQ_REQ: state <= ACQ_RESP;
              WR_REQ:  state <= WR_RESP;
              default: state <= TRIG_RESP;
            endcase
          end
        end
        ACQ_RESP: begin
          if (periph_r_valid_i) begin
            if (!periph_r_data_i[31]) begin
              job_id_o      <= periph_r_data_i[7:0];
              k             <= '0;
              periph_req_o  <= 1'b1;
              periph_add_o  <= job_addr('0);
              periph_wen_o  <= 1'b0;
              periph_data_o <= snap[0];
              state         <= WR_REQ;
            end else if (MAX_RETRY != 0 && retry_cnt == MAX_RETRY) begin
              error_o <= 1'b1;
              busy_o  <= 1'b0;
              state   <= IDLE;
            end else begin
              retry_cnt <= retry_cnt + 32'd1;
              bo_cnt    <= '0;
              state     <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          if (bo_cnt == BACKOFF_CYCLES - 1) begin
            periph_req_o  <= 1'b1;
            periph_add_o  <= ACQ_ADDR;
            periph_wen_o  <= 1'b1;
            periph_data_o <= '0;
            state         <= ACQ_REQ;
          end else begin
            bo_cnt <= bo_cnt + 32'd1;
          end
        end
        WR_RESP: begin
          if (periph_r_valid_i) begin
            periph_req_o <= 1'b1;
            periph_wen_o <= 1'b0;
            if (k == IDX_W'(N_JOB_REGS - 1)) begin
              evt_flag      <= 1'b0;
              periph_add_o  <= TRIG_ADDR;
              periph_data_o <= '0;
              state         <= TRIG_REQ;
            end else begin
              k             <= k_inc;
              periph_add_o  <= job_addr(k_inc);
              periph_data_o <= snap[k_inc];
              state         <= WR_REQ;
            end
          end
        end
        TRIG_RESP: begin
          if (evt_i) evt_flag <= 1'b1;
          if (periph_r_valid_i) state <= WAIT_EVT;
        end
        WAIT_EVT: begin
          if (evt_flag || evt_i) begin
            evt_flag <= 1'b0;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dataflow_job_dispatcher.sv
// Directed bench: behavioural periph slave with logging, expected bus traffic
// tables and hand-written sequences for retry, stall, event and reset cases.
module tb_multi_dataflow_job_dispatcher;

  localparam int N = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni, start_i, evt_i;
  logic [N*32-1:0] job_regs_i;
  logic            busy_o, done_o, error_o;
  logic [7:0]      job_id_o;
  logic            periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
  logic [31:0]     periph_add_o, periph_data_o, periph_r_data_i;
  logic [3:0]      periph_be_o;
  logic [9:0]      periph_id_o;

  multi_dataflow_job_dispatcher #(.MAX_RETRY(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .job_regs_i(job_regs_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .job_id_o(job_id_o),
    .evt_i(evt_i), .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i),
    .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o),
    .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
    .periph_r_data_i(periph_r_data_i), .periph_r_valid_i(periph_r_valid_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    int          req_cyc;
    int          gnt_cyc;
  } txn_t;

  typedef struct {
    string       name;
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
  } vec_t;

  txn_t        txq[$];
  logic [31:0] acq_q[$];
  logic [31:0] acq_default = 32'h0;
  logic [31:0] stall_addr = 32'h0;
  int          stall_left = 0;
  int          held_cnt = 0, unstable_cnt = 0;
  int          done_cnt = 0, error_cnt = 0, both_cnt = 0;
  bit          evt_req = 0, evt_with_trig = 0;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural slave: decides gnt at negedge, answers the cycle after grant.
  initial begin : slave
    bit          req_seen = 0, resp_pending = 0, resp_trig = 0;
    logic [31:0] resp_data = 0, h_add = 0, h_data = 0;
    logic        h_wen = 1;
    int          req_start = 0;
    periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = 0; evt_i = 0;
    forever begin
      @(negedge clk_i);
      periph_r_valid_i = 0;
      evt_i = evt_req;
      evt_req = 0;
      if (resp_pending) begin
        periph_r_valid_i = 1;
        periph_r_data_i  = resp_data;
        if (resp_trig && evt_with_trig) evt_i = 1;
        resp_pending = 0;
      end
      done_cnt  += int'(done_o);
      error_cnt += int'(error_o);
      if (done_o && error_o) both_cnt++;
      periph_gnt_i = 0;
      if (periph_req_o) begin
        if (!req_seen) begin
          req_seen = 1; req_start = cyc;
          h_add = periph_add_o; h_wen = periph_wen_o; h_data = periph_data_o;
        end else if (periph_add_o !== h_add || periph_wen_o !== h_wen || periph_data_o !== h_data) begin
          unstable_cnt++;
        end
        if (stall_left > 0 && periph_add_o == stall_addr) begin
          stall_left--;
          held_cnt++;
        end else begin
          periph_gnt_i = 1;
          txq.push_back('{periph_add_o, periph_wen_o, periph_data_o, req_start, cyc});
          resp_pending = 1;
          resp_trig = !periph_wen_o && periph_add_o == 32'h0;
          if (periph_wen_o && periph_add_o == 32'h4)
            resp_data = (acq_q.size() > 0) ? acq_q.pop_front() : acq_default;
          else
            resp_data = 32'h0;
          req_seen = 0;
        end
      end else begin
        req_seen = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [N*32-1:0] make_regs(input logic [31:0] base);
    logic [N*32-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic start_job(input logic [31:0] base);
    @(negedge clk_i);
    job_regs_i = make_regs(base);
    start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_log(input int n, input int maxc);
    for (int i = 0; i < maxc && txq.size() < n; i++) @(negedge clk_i);
    chk("log_reached", 32'(txq.size() >= n), 32'd1);
  endtask

  task automatic pulse_evt();
    @(posedge clk_i);
    #1 evt_req = 1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (done_o) begin at = cyc; break; end
    end
    chk("done_seen", 32'(at >= 0), 32'd1);
    if (at >= 0) begin
      chk("busy_with_done", 32'(busy_o), 32'd0);
      chk("no_error_with_done", 32'(error_o), 32'd0);
      @(negedge clk_i);
      chk("done_one_cycle", 32'(done_o), 32'd0);
    end
  endtask

  task automatic check_writes(input string tag, input int first, input logic [31:0] base);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_wr_add"},  txq[first+i].add,  32'h40 + 32'(4*i));
      chk({tag, "_wr_wen"},  32'(txq[first+i].wen), 32'd0);
      chk({tag, "_wr_data"}, txq[first+i].data, base + 32'(i));
    end
    chk({tag, "_trig_add"},  txq[first+N].add, 32'h0);
    chk({tag, "_trig_data"}, txq[first+N].data, 32'h0);
  endtask

  initial begin : main
    vec_t exp1[N+2];
    int   at, d0, g, gap, nwr, n44, err_at;

    exp1[0] = '{"acq_rd", 32'h4, 1'b1, 32'h0};
    for (int i = 0; i < N; i++) exp1[1+i] = '{"job_wr", 32'h40 + 32'(4*i), 1'b0, 32'hA0 + 32'(i)};
    exp1[N+1] = '{"trig_wr", 32'h0, 1'b0, 32'h0};

    rst_ni = 0; start_i = 0; job_regs_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_req",   32'(periph_req_o), 32'd0);
    chk("rst_wen",   32'(periph_wen_o), 32'd1);
    chk("rst_add",   periph_add_o, 32'h0);
    chk("rst_data",  periph_data_o, 32'h0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_jobid", 32'(job_id_o), 32'h0);
    chk("be_const",  32'(periph_be_o), 32'hF);
    chk("id_const",  32'(periph_id_o), 32'h0);
    rst_ni = 1;

    // Basic job, table-driven traffic check
    acq_q.push_back(32'h0);
    start_job(32'hA0);
    wait_log(N+2, 300);
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < N+2; i++) begin
      chk({exp1[i].name, "_add"},  txq[i].add, exp1[i].add);
      chk({exp1[i].name, "_wen"},  32'(txq[i].wen), 32'(exp1[i].wen));
      chk({exp1[i].name, "_data"}, txq[i].data, exp1[i].data);
    end
    chk("t1_jobid", 32'(job_id_o), 32'h0);
    @(negedge clk_i); start_i = 1; job_regs_i = make_regs(32'h55);
    @(negedge clk_i); start_i = 0;
    repeat (16) @(negedge clk_i);
    chk("t1_start_ignored", 32'(txq.size()), 32'(N+2));
    chk("t1_still_busy", 32'(busy_o), 32'd1);
    chk("t1_no_early_done", 32'(done_cnt), 32'd0);
    pulse_evt();
    wait_done(10, at);
    chk("t1_done_count", 32'(done_cnt), 32'd1);

    // Two busy ACQUIRE responses, then success with context 1
    txq.delete();
    acq_q.push_back(32'hFFFF_FFFE); acq_q.push_back(32'hFFFF_FFFE); acq_q.push_back(32'h1);
    start_job(32'hB0);
    wait_log(N+3, 500);
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      chk("t2_acq_add", txq[i].add, 32'h4);
      chk("t2_acq_wen", 32'(txq[i].wen), 32'd1);
    end
    for (int i = 1; i < 3; i++) begin
      gap = txq[i].req_cyc - (txq[i-1].gnt_cyc + 1) - 1;
      chk("t2_backoff_gap", 32'(gap >= 16), 32'd1);
    end
    chk("t2_jobid", 32'(job_id_o), 32'h1);
    check_writes("t2", 3, 32'hB0);
    pulse_evt();
    wait_done(10, at);
    chk("t2_error_count", 32'(error_cnt), 32'd0);

    // Retry limit exceeded
    txq.delete();
    acq_default = 32'hFFFF_FFFE;
    start_job(32'hD0);
    err_at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (error_o) begin err_at = cyc; break; end
    end
    chk("t3_error_seen", 32'(err_at >= 0), 32'd1);
    chk("t3_busy_low", 32'(busy_o), 32'd0);
    chk("t3_no_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    chk("t3_error_one_cycle", 32'(error_o), 32'd0);
    repeat (30) @(negedge clk_i);
    chk("t3_reads", 32'(txq.size()), 32'd3);
    nwr = 0;
    foreach (txq[i]) if (!txq[i].wen) nwr++;
    chk("t3_no_writes", 32'(nwr), 32'd0);
    if (txq.size() == 3) chk("t3_error_latency", 32'(err_at - txq[2].gnt_cyc), 32'd2);
    chk("t3_error_count", 32'(error_cnt), 32'd1);
    acq_default = 32'h0;

    // Grant stalled 5 cycles on write k=3; event during writes is ignored
    txq.delete();
    held_cnt = 0; unstable_cnt = 0;
    stall_addr = 32'h4C; stall_left = 5;
    acq_q.push_back(32'h7);
    d0 = done_cnt;
    start_job(32'hC0);
    wait_log(3, 200);
    pulse_evt();
    wait_log(N+2, 300);
    repeat (30) @(negedge clk_i);
    chk("t4_held", 32'(held_cnt), 32'd5);
    chk("t4_stable", 32'(unstable_cnt), 32'd0);
    n44 = 0;
    foreach (txq[i]) if (txq[i].add == 32'h4C) n44++;
    chk("t4_single_write", 32'(n44), 32'd1);
    check_writes("t4", 1, 32'hC0);
    chk("t4_jobid", 32'(job_id_o), 32'h7);
    chk("t4_evt_ignored", 32'(done_cnt - d0), 32'd0);
    chk("t4_still_busy", 32'(busy_o), 32'd1);
    pulse_evt();
    wait_done(10, at);

    // Event coincident with the TRIGGER response
    txq.delete();
    evt_with_trig = 1;
    acq_q.push_back(32'h2);
    d0 = done_cnt;
    start_job(32'hE0);
    wait_done(200, at);
    evt_with_trig = 0;
    if (txq.size() == N+2) begin
      g = txq[N+1].gnt_cyc;
      chk("t5_done_latency", 32'((at - (g + 1)) >= 1 && (at - (g + 1)) <= 2), 32'd1);
    end else begin
      chk("t5_txn_count", 32'(txq.size()), 32'(N+2));
    end
    chk("t5_done_count", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset while write k=2 is requested
    txq.delete();
    stall_addr = 32'h48; stall_left = 20;
    acq_q.push_back(32'h9);
    start_job(32'hF0);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (periph_req_o && periph_add_o == 32'h48) begin at = i; break; end
    end
    chk("t6_req_k2", 32'(at >= 0), 32'd1);
    #2 rst_ni = 0;
    #1;
    chk("t6_req_dropped", 32'(periph_req_o), 32'd0);
    chk("t6_busy_dropped", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
    stall_left = 0;
    chk("t6_jobid_reset", 32'(job_id_o), 32'h0);
    chk("t6_wen_reset", 32'(periph_wen_o), 32'd1);
    txq.delete();
    acq_q.delete();
    acq_q.push_back(32'h3);
    start_job(32'h10);
    wait_log(N+2, 300);
    repeat (3) @(negedge clk_i);
    chk("t6_acq_add", txq[0].add, 32'h4);
    chk("t6_acq_wen", 32'(txq[0].wen), 32'd1);
    check_writes("t6", 1, 32'h10);
    chk("t6_jobid", 32'(job_id_o), 32'h3);
    pulse_evt();
    wait_done(10, at);

    chk("never_done_and_error", 32'(both_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
